coin_vend_controller: RTL and testbench

Parameterised successor to the single-channel coin accumulator. It accumulates validated coins toward a configurable product price, fires a one-cycle vend pulse with computed change, and supports customer cancel and inactivity-timeout refunds. It sits between the coin-input front end and the dispense/change-return logic of the vending machine.

---
 rtl/coin_vend_controller.sv | 103 ++++++++++
 tb/tb_coin_vend_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/coin_vend_controller.sv
// Coin accumulator and vend controller: sums legal coins toward PRICE, vends with change,
// and refunds on customer cancel or inactivity timeout.
module coin_vend_controller #(
    parameter int unsigned TOTAL_W     = 6,
    parameter int unsigned PRICE       = 15,
    parameter logic [15:0] COIN_MASK   = 16'h0426,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [3:0]         coin,
    input  logic               cancel,
    output logic [TOTAL_W-1:0] total,
    output logic               coin_reject,
    output logic               vend_pulse,
    output logic               refund,
    output logic [TOTAL_W-1:0] change,
    output logic               change_valid,
    output logic               busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [TOTAL_W-1:0] PRICE_W = TOTAL_W'(PRICE);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;
    localparam logic [1:0] REFUND  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reject_q, reject_d;
    logic               accept;
    logic [TOTAL_W-1:0] sum;

    assign accept = coin_valid && COIN_MASK[coin] && !cancel &&
                    ((state_q == IDLE) || (state_q == COLLECT));
    assign sum    = total_q + {{(TOTAL_W-4){1'b0}}, coin};
    assign reject_d = coin_valid && !accept;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    total_d = sum;
                    state_d = (sum >= PRICE_W) ? VEND : COLLECT;
                end
            end
            COLLECT: begin
                // Cancel wins over a coin presented in the same cycle.
                if (cancel) begin
                    state_d = REFUND;
                end else if (accept) begin
                    total_d = sum;
                    if (sum >= PRICE_W) state_d = VEND;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    state_d = REFUND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                total_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            total_q  <= '0;
            cnt_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        change = '0;
        if (state_q == VEND)   change = total_q - PRICE_W;
        if (state_q == REFUND) change = total_q;
    end

    assign total        = total_q;
    assign coin_reject  = reject_q;
    assign vend_pulse   = (state_q == VEND);
    assign refund       = (state_q == REFUND);
    assign change_valid = (state_q == VEND) || (state_q == REFUND);
    assign busy         = change_valid;

endmodule

// File: tb/tb_coin_vend_controller.sv
// Directed bench for coin_vend_controller with default parameters (PRICE=15, timeout 16).
module tb_coin_vend_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin;
    logic       cancel;
    logic [5:0] total;
    logic       coin_reject;
    logic       vend_pulse;
    logic       refund;
    logic [5:0] change;
    logic       change_valid;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    coin_vend_controller dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .cancel      (cancel),
        .total       (total),
        .coin_reject (coin_reject),
        .vend_pulse  (vend_pulse),
        .refund      (refund),
        .change      (change),
        .change_valid(change_valid),
        .busy        (busy)
    );

    typedef struct {
        logic       cv;
        logic [3:0] c;
        logic       can;
        logic [5:0] e_total;
        logic       e_rej;
        logic       e_vend;
        logic       e_ref;
        logic [5:0] e_change;
        logic       e_cvld;
        logic       e_busy;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int t, input int rj, input int v,
                             input int rf, input int ch, input int cvld, input int b);
        check({tag, ".total"}, int'(total), t);
        check({tag, ".coin_reject"}, int'(coin_reject), rj);
        check({tag, ".vend_pulse"}, int'(vend_pulse), v);
        check({tag, ".refund"}, int'(refund), rf);
        check({tag, ".change"}, int'(change), ch);
        check({tag, ".change_valid"}, int'(change_valid), cvld);
        check({tag, ".busy"}, int'(busy), b);
    endtask

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic cv, input logic [3:0] c, input logic can);
        coin_valid = cv;
        coin       = c;
        cancel     = can;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //           cv  c   can total rej vnd ref chg cvld busy
        vecs[0]  = '{1, 5,  0, 5,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 10, 0, 15, 0, 1, 0, 0, 1, 1};
        vecs[2]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 10, 0, 10, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 10, 0, 20, 0, 1, 0, 5, 1, 1};
        vecs[5]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 3,  0, 0,  1, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 7,  0, 0,  1, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 5,  0, 5,  0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 10, 1, 5,  1, 0, 1, 5, 1, 1};
        vecs[11] = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 10, 0, 10, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{1, 5,  0, 15, 0, 1, 0, 0, 1, 1};
        vecs[14] = '{1, 5,  0, 0,  1, 0, 0, 0, 0, 0};
        vecs[15] = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[16] = '{1, 5,  1, 0,  1, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};
        vecs[18] = '{1, 0,  0, 0,  1, 0, 0, 0, 0, 0};
        vecs[19] = '{1, 1,  0, 1,  0, 0, 0, 0, 0, 0};
        vecs[20] = '{0, 0,  1, 1,  0, 0, 1, 1, 1, 1};
        vecs[21] = '{1, 2,  0, 0,  1, 0, 0, 0, 0, 0};
        vecs[22] = '{0, 0,  0, 0,  0, 0, 0, 0, 0, 0};

        coin_valid = 1'b0;
        coin       = '0;
        cancel     = 1'b0;
        do_reset();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].cv, vecs[i].c, vecs[i].can);
            check_all($sformatf("vec%0d", i), vecs[i].e_total, vecs[i].e_rej, vecs[i].e_vend,
                      vecs[i].e_ref, vecs[i].e_change, vecs[i].e_cvld, vecs[i].e_busy);
        end

        // Timeout: coin 2 then 16 idle cycles; refund lands on the 16th.
        step(1, 2, 0);
        check("to.total", int'(total), 2);
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 0);
            check($sformatf("to.idle%0d.refund", k), int'(refund), 0);
        end
        step(0, 0, 0);
        check_all("to.fire", 2, 0, 0, 1, 2, 1, 1);
        step(0, 0, 0);
        check_all("to.after", 0, 0, 0, 0, 0, 0, 0);

        // Coin at idle cycle 10 restarts the count.
        step(1, 2, 0);
        for (int k = 1; k <= 9; k++) step(0, 0, 0);
        step(1, 1, 0);
        check("rs.total", int'(total), 3);
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 0);
            check($sformatf("rs.idle%0d.refund", k), int'(refund), 0);
        end
        step(0, 0, 0);
        check_all("rs.fire", 3, 0, 0, 1, 3, 1, 1);
        step(0, 0, 0);

        // Async reset mid-COLLECT clears credit before any clock edge.
        step(1, 10, 0);
        check("rc.total", int'(total), 10);
        #2 rst = 1'b1;
        #1;
        check_all("rc.async", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset during VEND suppresses the pulse immediately.
        step(1, 10, 0);
        coin_valid = 1'b1;
        coin       = 4'd5;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        check("rv.vend", int'(vend_pulse), 1);
        #2 rst = 1'b1;
        #1;
        check_all("rv.async", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset clears a pending reject pulse.
        step(1, 3, 0);
        check("rr.reject", int'(coin_reject), 1);
        #2 rst = 1'b1;
        #1;
        check("rr.async.reject", int'(coin_reject), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 0, 0);
        check_all("rr.after", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
